// File: rtl/bmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// bmem_responder_pkg
// Shared bmem protocol types and constants: beat/line geometry, the line type
// used by the array and the response path, and the read-queue entry that
// carries the line address plus the cycle stamp of its acceptance.
// -----------------------------------------------------------------------------
package bmem_responder_pkg;

    localparam int BMEM_BEATS       = 4;
    localparam int BMEM_BEAT_WIDTH  = 64;
    localparam int BMEM_LINE_WIDTH  = BMEM_BEATS * BMEM_BEAT_WIDTH;
    localparam int BMEM_ADDR_WIDTH  = 32;
    // Byte-offset bits inside one line (32 B -> 5 bits).
    localparam int BMEM_OFFSET_BITS = $clog2(BMEM_LINE_WIDTH / 8);

    // Width of the free-running acceptance stamp. Ages are compared by
    // difference, so only the longest possible wait in the queue has to fit.
    localparam int STAMP_WIDTH      = 16;

    // One cache line as an array of beats; element 0 is beat 0 (bits 63:0).
    typedef logic [BMEM_BEATS-1:0][BMEM_BEAT_WIDTH-1:0] line_t;

    typedef struct packed {
        logic [BMEM_ADDR_WIDTH-1:0] addr;
        logic [STAMP_WIDTH-1:0]     stamp;
    } rq_entry_t;

    function automatic logic is_aligned(input logic [BMEM_OFFSET_BITS-1:0] offset);
        return offset == '0;
    endfunction

endpackage

// File: rtl/bmem_read_queue.sv
// -----------------------------------------------------------------------------
// bmem_read_queue
// Circular FIFO of outstanding read requests with wrap-around pointers.
// A push and a pop in the same cycle keep the occupancy constant.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset (empties the queue)
//   push_i         write push_entry_i at the tail (ignored when full)
//   push_entry_i   entry to enqueue
//   pop_i          drop the head entry (ignored when empty)
//   head_o         oldest entry
//   next_o         entry behind the head (valid when count_o >= 2)
//   count_o        current occupancy
//   full_o/empty_o occupancy flags
// -----------------------------------------------------------------------------
module bmem_read_queue
    import bmem_responder_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  rq_entry_t                push_entry_i,
    input  logic                     pop_i,
    output rq_entry_t                head_o,
    output rq_entry_t                next_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    rq_entry_t          slots_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_next;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               do_pop;

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign do_push     = push_i & ~full_o;
    assign do_pop      = pop_i & ~empty_o;
    assign rd_ptr_next = rd_ptr_q + PTR_W'(1);

    assign head_o  = slots_q[rd_ptr_q];
    assign next_o  = slots_q[rd_ptr_next];
    assign count_o = count_q;

    // NOTE: storage slots carry no reset; only pointers and count define
    // which slots are live, so clearing the array would buy nothing.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots_q[wr_ptr_q] <= push_entry_i;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_next;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/bmem_responder.sv
// -----------------------------------------------------------------------------
// bmem_responder
// Memory-side end of the bmem burst protocol. Accepts one-cycle line reads and
// four-beat line writes, and returns read data as in-order 4-beat bursts a
// fixed LATENCY after acceptance. Protocol violations raise a sticky flag.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   bmem_addr    request line address (32 B aligned)
//   bmem_read    read request, one cycle per line
//   bmem_write   write beat valid, 4 consecutive cycles per line
//   bmem_wdata   write beat data, beat 0 first
//   bmem_ready   a request can be accepted this cycle
//   bmem_raddr   line address of the current read beat
//   bmem_rdata   read beat data, beat 0 first
//   bmem_rvalid  read beat valid
//   proto_err    sticky protocol-violation flag
// -----------------------------------------------------------------------------
module bmem_responder
    import bmem_responder_pkg::*;
#(
    parameter int MEM_LINES = 1024,
    parameter int LATENCY   = 8,
    parameter int RQ_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bmem_addr,
    input  logic        bmem_read,
    input  logic        bmem_write,
    input  logic [63:0] bmem_wdata,
    output logic        bmem_ready,
    output logic [31:0] bmem_raddr,
    output logic [63:0] bmem_rdata,
    output logic        bmem_rvalid,
    output logic        proto_err
);

    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = $clog2(RQ_DEPTH) + 1;

    // A head entry is ripe once its age reaches LATENCY-1; the burst then
    // starts on the following edge, putting beat 0 LATENCY cycles after accept.
    localparam logic [STAMP_WIDTH-1:0] RIPE_AGE  = STAMP_WIDTH'(LATENCY - 1);
    localparam logic [1:0]             LAST_BEAT = 2'(BMEM_BEATS - 1);

    localparam logic RS_IDLE  = 1'b0;
    localparam logic RS_BURST = 1'b1;
    localparam logic W_IDLE   = 1'b0;
    localparam logic W_BEAT   = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    line_t                  mem_q [MEM_LINES];
    logic [STAMP_WIDTH-1:0] cycle_q;
    logic                   alive_q;
    logic                   err_q;

    logic                   wr_state_q, wr_state_d;
    logic [1:0]             wr_beat_q,  wr_beat_d;
    logic [31:0]            wr_addr_q,  wr_addr_d;
    line_t                  wr_buf_q,   wr_buf_d;

    logic                   rs_state_q, rs_state_d;
    logic [1:0]             rs_beat_q,  rs_beat_d;
    logic [31:0]            raddr_q,    raddr_d;
    line_t                  line_q,     line_d;

    // ------------------------------------------------------------------
    // Read queue
    // ------------------------------------------------------------------
    rq_entry_t              q_head;
    rq_entry_t              q_next;
    rq_entry_t              push_entry;
    logic [CNT_W-1:0]       q_count;
    logic                   q_full;
    logic                   q_empty;
    logic                   rd_accept;
    logic                   pop;

    // Stamp with the counter value seen after the accepting edge.
    assign push_entry = '{addr: bmem_addr, stamp: cycle_q + STAMP_WIDTH'(1)};

    bmem_read_queue #(
        .DEPTH (RQ_DEPTH)
    ) u_read_queue (
        .clk          (clk),
        .rst          (rst),
        .push_i       (rd_accept),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (q_head),
        .next_o       (q_next),
        .count_o      (q_count),
        .full_o       (q_full),
        .empty_o      (q_empty)
    );

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic aligned;
    logic rd_misaligned;
    logic wr_misaligned;
    logic wr_abort;
    logic commit;
    logic err_now;

    // A write burst in progress keeps ready high even with a full queue.
    assign bmem_ready = alive_q & (~q_full | (wr_state_q == W_BEAT));
    assign aligned    = is_aligned(bmem_addr[BMEM_OFFSET_BITS-1:0]);

    assign rd_accept     = bmem_read & ~bmem_write & bmem_ready &
                           (wr_state_q == W_IDLE) & aligned;
    assign rd_misaligned = bmem_read & ~bmem_write & bmem_ready &
                           (wr_state_q == W_IDLE) & ~aligned;

    assign err_now = (bmem_read & bmem_write) | wr_abort | wr_misaligned | rd_misaligned;

    // ------------------------------------------------------------------
    // Write collector
    // ------------------------------------------------------------------
    // NOTE: every signal assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_state_d    = wr_state_q;
        wr_beat_d     = wr_beat_q;
        wr_addr_d     = wr_addr_q;
        wr_buf_d      = wr_buf_q;
        commit        = 1'b0;
        wr_abort      = 1'b0;
        wr_misaligned = 1'b0;

        if (wr_state_q == W_IDLE) begin
            if (bmem_write & ~bmem_read & bmem_ready) begin
                if (aligned) begin
                    wr_state_d  = W_BEAT;
                    wr_beat_d   = 2'd1;
                    wr_addr_d   = bmem_addr;
                    wr_buf_d[0] = bmem_wdata;
                end else begin
                    wr_misaligned = 1'b1;
                end
            end
        end else begin
            // Any deviation (dropped write, read, moved address) kills the line.
            if (bmem_write & ~bmem_read & (bmem_addr == wr_addr_q)) begin
                wr_buf_d[wr_beat_q] = bmem_wdata;
                if (wr_beat_q == LAST_BEAT) begin
                    commit     = 1'b1;
                    wr_state_d = W_IDLE;
                    wr_beat_d  = '0;
                end else begin
                    wr_beat_d  = wr_beat_q + 2'd1;
                end
            end else begin
                wr_abort   = 1'b1;
                wr_state_d = W_IDLE;
                wr_beat_d  = '0;
            end
        end
    end

    logic [IDX_W-1:0] commit_idx;
    assign commit_idx = wr_addr_q[BMEM_OFFSET_BITS +: IDX_W];

    always_ff @(posedge clk) begin
        if (commit) begin
            mem_q[commit_idx] <= wr_buf_d;
        end
    end

    // ------------------------------------------------------------------
    // Response engine
    // ------------------------------------------------------------------
    logic             head_ripe;
    logic             next_ripe;
    logic             start;
    rq_entry_t        start_entry;
    logic [IDX_W-1:0] start_idx;
    line_t            start_line;

    assign head_ripe = ~q_empty & ((cycle_q - q_head.stamp) >= RIPE_AGE);
    assign next_ripe = (q_count > CNT_W'(1)) & ((cycle_q - q_next.stamp) >= RIPE_AGE);

    always_comb begin
        rs_state_d  = rs_state_q;
        rs_beat_d   = rs_beat_q;
        raddr_d     = raddr_q;
        line_d      = line_q;
        pop         = 1'b0;
        start       = 1'b0;
        start_entry = q_head;

        if (rs_state_q == RS_IDLE) begin
            start = head_ripe;
        end else if (rs_beat_q == LAST_BEAT) begin
            // The head leaves on its last beat; the entry behind it can start
            // on the same edge, giving gap-free back-to-back bursts.
            pop         = 1'b1;
            rs_state_d  = RS_IDLE;
            start       = next_ripe;
            start_entry = q_next;
        end else begin
            rs_beat_d = rs_beat_q + 2'd1;
        end

        // A line committed on the same edge is forwarded so the burst sees it.
        start_idx = start_entry.addr[BMEM_OFFSET_BITS +: IDX_W];
        if (commit && (commit_idx == start_idx)) begin
            start_line = wr_buf_d;
        end else begin
            start_line = mem_q[start_idx];
        end

        if (start) begin
            rs_state_d = RS_BURST;
            rs_beat_d  = '0;
            raddr_d    = start_entry.addr;
            line_d     = start_line;
        end
    end

    assign bmem_rvalid = (rs_state_q == RS_BURST);
    assign bmem_raddr  = raddr_q;
    assign bmem_rdata  = line_q[rs_beat_q];
    assign proto_err   = err_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q    <= '0;
            alive_q    <= 1'b0;
            err_q      <= 1'b0;
            wr_state_q <= W_IDLE;
            wr_beat_q  <= '0;
            wr_addr_q  <= '0;
            wr_buf_q   <= '0;
            rs_state_q <= RS_IDLE;
            rs_beat_q  <= '0;
            raddr_q    <= '0;
            line_q     <= '0;
        end else begin
            cycle_q    <= cycle_q + STAMP_WIDTH'(1);
            alive_q    <= 1'b1;
            err_q      <= err_q | err_now;
            wr_state_q <= wr_state_d;
            wr_beat_q  <= wr_beat_d;
            wr_addr_q  <= wr_addr_d;
            wr_buf_q   <= wr_buf_d;
            rs_state_q <= rs_state_d;
            rs_beat_q  <= rs_beat_d;
            raddr_q    <= raddr_d;
            line_q     <= line_d;
        end
    end

endmodule
